// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared definitions for the register-bank read controller:
//                default widths, read-controller state encoding and the
//                reset value of the returned operands.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default widths: 4-bit registers, 2-bit select (4 registers).
    localparam int unsigned REGFILE_DATA_W = 4;
    localparam int unsigned REGFILE_ADDR_W = 2;

    // Value loaded into the operand registers on reset.
    localparam logic [REGFILE_DATA_W-1:0] DATA_RST = '0;

    // Read controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        RESP = 2'd3
    } rd_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_mux.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_mux
//  Description : Single shared 4:1 read mux over the register bank outputs.
//                When forwarding is enabled, a bank write to the selected
//                register in the same cycle overrides the bank output so the
//                newest value is returned.
//  Ports       : i_reg0..i_reg3 - bank register outputs
//                i_sel          - register select
//                i_wr_en        - snooped bank write enable
//                i_wr_addr      - snooped bank write select
//                i_wr_data      - snooped bank write data
//                o_data         - selected (possibly forwarded) value
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_mux
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REGFILE_DATA_W,
    parameter int unsigned ADDR_W = REGFILE_ADDR_W,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic [DATA_W-1:0] i_reg0,
    input  logic [DATA_W-1:0] i_reg1,
    input  logic [DATA_W-1:0] i_reg2,
    input  logic [DATA_W-1:0] i_reg3,
    input  logic [ADDR_W-1:0] i_sel,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_bank_data;
    logic              w_fwd_hit;

    always_comb begin
        w_bank_data = i_reg0;
        case (i_sel)
            ADDR_W'(0): w_bank_data = i_reg0;
            ADDR_W'(1): w_bank_data = i_reg1;
            ADDR_W'(2): w_bank_data = i_reg2;
            ADDR_W'(3): w_bank_data = i_reg3;
            default:    w_bank_data = i_reg0;
        endcase
    end

    // The bank only commits the write at the coming edge, so its output still
    // shows the old value this cycle; take the write data instead.
    assign w_fwd_hit = FWD_EN && i_wr_en && (i_wr_addr == i_sel);
    assign o_data    = w_fwd_hit ? i_wr_data : w_bank_data;

endmodule : regfile_read_mux
`default_nettype wire

// File: rtl/regfile_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_ctrl
//  Description : Read-side controller for the 4x4 register bank. Serves
//                two-operand (rs1, rs2) read requests through one shared
//                read mux, reading rs1 then rs2 on successive cycles, and
//                returns a snapshot of both operands with a valid/ready
//                response handshake.
//  Ports       : clk, rst                   - clock, sync active-high reset
//                reg0_in..reg3_in           - bank register outputs
//                RegWrite/Write_register/
//                write_data                 - snooped bank write port
//                req_valid/req_ready        - request handshake
//                rs1_addr/rs2_addr          - operand selects (on accept)
//                rsp_valid/rsp_ready        - response handshake
//                rs1_data/rs2_data          - returned operands
//                busy                       - controller not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REGFILE_DATA_W,
    parameter int unsigned ADDR_W = REGFILE_ADDR_W,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] reg0_in,
    input  logic [DATA_W-1:0] reg1_in,
    input  logic [DATA_W-1:0] reg2_in,
    input  logic [DATA_W-1:0] reg3_in,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              busy
);

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_rs1_addr;
    logic [ADDR_W-1:0] r_rs2_addr;
    logic [DATA_W-1:0] r_rs1_data;
    logic [DATA_W-1:0] r_rs2_data;
    logic [ADDR_W-1:0] w_rd_sel;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_same_addr;

    assign w_same_addr = (r_rs1_addr == r_rs2_addr);

    // The single read mux serves rs1 in RD1 and rs2 in RD2.
    assign w_rd_sel = (r_state == RD2) ? r_rs2_addr : r_rs1_addr;

    regfile_read_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FWD_EN (FWD_EN)
    ) u_read_mux (
        .i_reg0    (reg0_in),
        .i_reg1    (reg1_in),
        .i_reg2    (reg2_in),
        .i_reg3    (reg3_in),
        .i_sel     (w_rd_sel),
        .i_wr_en   (RegWrite),
        .i_wr_addr (Write_register),
        .i_wr_data (write_data),
        .o_data    (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_state_nxt = RD1;
                end
            end
            RD1: begin
                // Equal selects need only one read; RD2 is skipped.
                w_state_nxt = w_same_addr ? RESP : RD2;
            end
            RD2: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand and address registers. Operands change only in RD1/RD2, so
    // they form a snapshot that later bank writes cannot disturb.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rs1_data <= DATA_W'(DATA_RST);
            r_rs2_data <= DATA_W'(DATA_RST);
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_rs1_addr <= rs1_addr;
                        r_rs2_addr <= rs2_addr;
                    end
                end
                RD1: begin
                    r_rs1_data <= w_rd_data;
                    if (w_same_addr) begin
                        r_rs2_data <= w_rd_data;
                    end
                end
                RD2: begin
                    r_rs2_data <= w_rd_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign rs1_data = r_rs1_data;
    assign rs2_data = r_rs2_data;

endmodule : regfile_read_ctrl
`default_nettype wire

// File: tb/tb_regfile_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_read_ctrl
//  Description : Self-checking bench for regfile_read_ctrl. A behavioural
//                model computes each response from the bank contents at the
//                capture cycles and queues it; a monitor compares whatever
//                the DUT presents against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_read_ctrl;

    localparam int unsigned DW  = 4;
    localparam int unsigned AW  = 2;
    localparam bit          FWD = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          RegWrite;
    logic [AW-1:0] Write_register;
    logic [DW-1:0] write_data;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic          busy;

    logic [DW-1:0] bank [4];
    int            cyc = 0;
    logic          rst_at_edge = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
        int            rise;
    } exp_t;
    exp_t expq[$];

    // model state for the request in flight
    logic          pend = 1'b0;
    int            p_c  = 0;
    logic [AW-1:0] p_a1 = '0;
    logic [AW-1:0] p_a2 = '0;
    logic [DW-1:0] p_v1 = '0;

    int   rdy_mode = 0;     // 0: always ready, 1: never, 2: random
    logic wr_rand  = 1'b0;

    always #5 clk = ~clk;

    regfile_read_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .FWD_EN (FWD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .reg0_in        (bank[0]),
        .reg1_in        (bank[1]),
        .reg2_in        (bank[2]),
        .reg3_in        (bank[3]),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .write_data     (write_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .busy           (busy)
    );

    // Register bank behaviour: write commits at the clock edge.
    always @(posedge clk) begin
        if (RegWrite) bank[Write_register] <= write_data;
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Newest value of register a as seen at the coming edge.
    function automatic logic [DW-1:0] newest(input logic [AW-1:0] a);
        if (FWD && RegWrite && (Write_register == a)) return write_data;
        return bank[a];
    endfunction

    // Reference model: evaluated at each negedge for the coming posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                expq.delete();
            end else begin
                chk("req_ready", int'(req_ready), int'(!(pend || expq.size() != 0)));
                if (pend) begin
                    if (cyc == p_c + 1) begin
                        p_v1 = newest(p_a1);
                        if (p_a1 == p_a2) begin
                            expq.push_back('{v1: p_v1, v2: p_v1, rise: p_c + 2});
                            pend = 1'b0;
                        end
                    end else if (cyc == p_c + 2) begin
                        expq.push_back('{v1: p_v1, v2: newest(p_a2), rise: p_c + 3});
                        pend = 1'b0;
                    end
                end
                if (req_valid && req_ready) begin
                    pend = 1'b1;
                    p_c  = cyc;
                    p_a1 = rs1_addr;
                    p_a2 = rs2_addr;
                end
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queue.
    initial begin
        logic in_rsp;
        exp_t e;
        in_rsp = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_at_edge) begin
                chk("rst_rsp_valid", int'(rsp_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_req_ready", int'(req_ready), 1);
                chk("rst_data", int'({rs1_data, rs2_data}), 0);
            end
            if (rst) begin
                in_rsp = 1'b0;
            end else begin
                chk("busy_vs_ready", int'(busy), int'(!req_ready));
                if (rsp_valid) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_rsp", int'(rsp_valid), 0);
                    end else begin
                        e = expq[0];
                        chk("rs1_data", int'(rs1_data), int'(e.v1));
                        chk("rs2_data", int'(rs2_data), int'(e.v2));
                        if (!in_rsp) chk("rsp_latency_cycle", cyc, e.rise);
                        in_rsp = 1'b1;
                        if (rsp_ready) begin
                            void'(expq.pop_front());
                            in_rsp = 1'b0;
                        end
                    end
                end else if (in_rsp) begin
                    chk("rsp_valid_dropped", int'(rsp_valid), 1);
                    in_rsp = 1'b0;
                end
            end
        end
    end

    // One cycle: advance to just after the edge, drive per-cycle inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
        if (wr_rand) begin
            RegWrite       = 1'($urandom_range(0, 1));
            Write_register = AW'($urandom_range(0, 3));
            write_data     = DW'($urandom_range(0, 15));
        end else begin
            RegWrite = 1'b0;
        end
    endtask

    // Present a request and hold it until accepted; returns in the RD1 cycle.
    task automatic do_req(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        logic acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        rs1_addr  = a1;
        rs2_addr  = a2;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = req_ready;
            tick();
        end
        if (!acc) chk("req_accept_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    // Wait for the controller to return to IDLE, optionally issuing
    // junk requests while it is busy.
    task automatic settle(input logic junk);
        logic rdy;
        rdy = 1'b0;
        for (int n = 0; n < 100 && !rdy; n++) begin
            @(negedge clk);
            rdy = req_ready;
            tick();
            if (junk && !rdy) begin
                req_valid = 1'($urandom_range(0, 1));
                rs1_addr  = AW'($urandom_range(0, 3));
                rs2_addr  = AW'($urandom_range(0, 3));
            end
        end
        if (!rdy) chk("idle_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] init_v [4];
        init_v         = '{4'h3, 4'hA, 4'h5, 4'hC};
        rst            = 1'b1;
        req_valid      = 1'b0;
        rs1_addr       = '0;
        rs2_addr       = '0;
        RegWrite       = 1'b0;
        Write_register = '0;
        write_data     = '0;
        rsp_ready      = 1'b1;

        // Load the bank while the controller is held in reset.
        for (int i = 0; i < 4; i++) begin
            tick();
            RegWrite       = 1'b1;
            Write_register = AW'(i);
            write_data     = init_v[i];
        end
        tick();
        tick();
        rst = 1'b0;

        // Distinct and equal addresses.
        do_req(2'd1, 2'd2); settle(1'b0);
        do_req(2'd3, 2'd3); settle(1'b0);

        // Write to rs1's register during RD1 is forwarded.
        do_req(2'd0, 2'd1);
        RegWrite = 1'b1; Write_register = 2'd0; write_data = 4'h9;
        settle(1'b0);

        // Backpressure with a write to reg1 while the response waits.
        rdy_mode = 1;
        do_req(2'd1, 2'd2);
        tick();
        tick();
        RegWrite = 1'b1; Write_register = 2'd1; write_data = 4'hF;
        repeat (4) tick();
        rdy_mode = 0;
        settle(1'b0);

        // Reset while in RD2, then a normal request.
        do_req(2'd0, 2'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_req(2'd2, 2'd1); settle(1'b0);

        // Random traffic with random writes, backpressure and busy requests.
        wr_rand  = 1'b1;
        rdy_mode = 2;
        repeat (40) begin
            do_req(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
            settle(1'b1);
        end
        wr_rand  = 1'b0;
        rdy_mode = 0;
        settle(1'b0);
        repeat (3) tick();
        chk("leftover_expected", int'(pend) + expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_read_ctrl
`default_nettype wire

// File: doc/regfile_read_ctrl.md
Name: regfile_read_ctrl

Overview:
- Read-side controller for the 4x4 register bank. It takes the bank's four parallel register outputs and serves two-operand read requests (rs1, rs2) through one shared 4:1 read mux, time-multiplexed over successive cycles.
- Requests and responses use valid/ready handshakes.
- Snoops the bank's write port and forwards a same-cycle write, so returned operands always reflect the newest value.
- Sits between the register bank and the ALU/LED display path.

Parameters:
- DATA_W, 4, register width in bits.
- ADDR_W, 2, register select width; the bank holds 2**ADDR_W = 4 registers.
- FWD_EN, 1, 1 = forward a snooped write into the capture; 0 = capture raw bank output.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- reg0_in  input  DATA_W  bank register 0 output.
- reg1_in  input  DATA_W  bank register 1 output.
- reg2_in  input  DATA_W  bank register 2 output.
- reg3_in  input  DATA_W  bank register 3 output.
- RegWrite  input  1  bank write enable (snooped).
- Write_register  input  ADDR_W  bank write select (snooped).
- write_data  input  DATA_W  bank write data (snooped).
- req_valid  input  1  read request valid.
- req_ready  output  1  controller can accept a request.
- rs1_addr  input  ADDR_W  first operand select; sampled on accept.
- rs2_addr  input  ADDR_W  second operand select; sampled on accept.
- rsp_valid  output  1  rs1_data/rs2_data are valid.
- rsp_ready  input  1  consumer accepts the response.
- rs1_data  output  DATA_W  first operand.
- rs2_data  output  DATA_W  second operand.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, RD1, RD2, RESP.
- Reset (rst=1 at posedge) from any state, including mid-operation:
  - state = IDLE.
  - req_ready = 1, rsp_valid = 0, busy = 0.
  - rs1_data = rs2_data = 0; latched addresses = 0.
  - Any pending response is discarded.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch rs1_addr and rs2_addr, then go to RD1.
- RD1:
  - Shared mux selects the latched rs1 address.
  - At the edge, capture into rs1_data:
    - write_data if FWD_EN && RegWrite && Write_register == latched rs1 address;
    - otherwise the mux output.
  - Next state: RESP if the two latched addresses are equal (rs2_data gets the same captured value), else RD2.
- RD2:
  - Same rule as RD1, applied to the latched rs2 address and captured into rs2_data.
  - Next state: RESP.
- RESP:
  - rsp_valid = 1.
  - rs1_data and rs2_data are held stable; later writes to the bank do not alter them (snapshot semantics).
  - On rsp_ready, go to IDLE.
  - rsp_valid must not drop before acceptance.
- Outputs:
  - req_ready is asserted only in IDLE. A request is never accepted in the same cycle as a response handshake, so back-to-back throughput is one request per 3-4 cycles.
  - rs1_data/rs2_data are registered and hold their last value outside RESP.
- Latency from the accept edge to rsp_valid: 3 cycles for distinct addresses, 2 cycles for equal addresses.
- Boundary cases:
  - Address 3 selects reg3_in; there is no wrap or out-of-range case.
  - req_valid while busy is ignored; the requester must hold it until req_ready.
  - rsp_ready asserted before RESP has no effect.
  - A write to rs2's register during RD1 is not forwarded. rs2 is read in RD2, by which time the bank already holds the new value, so it is returned correctly.
- There is exactly one read mux instance; no parallel read paths.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W and ADDR_W defaults;
  - the state enum (IDLE=2'd0, RD1=2'd1, RD2=2'd2, RESP=2'd3);
  - the reset value DATA_RST = 0.
- One sub-module, regfile_read_mux: combinational 4:1 mux over reg0_in..reg3_in with the forward override, instantiated once.

Test Plan:
- Reset and distinct addresses:
  - Stimulus: rst held 2 cycles with regs = {0x3, 0xA, 0x5, 0xC}; request rs1=1, rs2=2.
  - Response: outputs 0 during reset; rsp_valid rises 3 cycles after accept with rs1=0xA, rs2=0x5; req_ready=0 until the response is accepted.
- Equal addresses:
  - Stimulus: request rs1=3, rs2=3.
  - Response: rsp_valid 2 cycles after accept; rs1=rs2=0xC; RD2 never entered.
- Forwarding during RD1:
  - Stimulus: RegWrite=1, Write_register=0, write_data=0x9 in the RD1 cycle of request rs1=0, rs2=1.
  - Response: rs1=0x9 (not 0x3) with FWD_EN=1; rs1=0x3 with FWD_EN=0.
- Backpressure and snapshot:
  - Stimulus: hold rsp_ready=0 for 5 cycles while a write puts 0xF into reg1.
  - Response: rsp_valid stays 1; rs1/rs2 stay 0xA/0x5; IDLE entered the cycle after rsp_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst in RD2.
  - Response: next cycle state=IDLE, busy=0, rsp_valid=0, rs1=rs2=0; a subsequent request completes normally.
- Request while busy:
  - Stimulus: toggle req_valid with new addresses during RD1 and RESP.
  - Response: ignored; the response reflects only the originally accepted addresses.
